// File: rtl/mips_cpu_store_unit.sv
// mips_cpu_store_unit
// Takes one MIPS store (sb/sh/sw/swl/swr) at a time. It maps the store onto
// a 32-bit little-endian word bus with byte enables, then runs the bus write
// until the bus stops stalling.
//
// Ports
//   i_clk, i_reset      clock; synchronous active-high reset
//   i_req_valid         store request present
//   o_req_ready         unit idle and able to accept a request
//   i_opcode[5:0]       MIPS store opcode
//   i_addr[31:0]        effective byte address
//   i_rt_data[31:0]     source register value
//   o_address[31:0]     bus word address (zero when idle)
//   o_write             bus write strobe
//   o_byteenable[3:0]   bus lane enables (zero when idle)
//   o_writedata[31:0]   bus write data, disabled lanes zero (zero when idle)
//   i_waitrequest       bus stall
//   o_done              one-cycle pulse: store completed on the bus
//   o_err               one-cycle pulse: request rejected or write timed out
//
// state | meaning
// IDLE  | req_ready high, bus outputs zero, waiting for a request
// WRITE | bus write in progress, outputs held until waitrequest drops
module mips_cpu_store_unit #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [5:0]  i_opcode,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_rt_data,
  output logic [31:0] o_address,
  output logic        o_write,
  output logic [3:0]  o_byteenable,
  output logic [31:0] o_writedata,
  input  logic        i_waitrequest,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SWL = 6'b101010;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SWR = 6'b101110;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_address;
  logic [3:0]  r_byteenable;
  logic [31:0] r_writedata;
  logic [31:0] r_wait_cnt;
  logic        r_done;
  logic        r_err;

  logic [1:0]  w_a;
  logic        w_legal;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic        w_accept;
  logic        w_clear;
  logic        w_done_nxt;
  logic        w_err_nxt;
  logic [31:0] w_cnt_inc;
  logic [31:0] w_cnt_nxt;
  logic        w_timeout;

  assign w_a       = i_addr[1:0];
  assign w_cnt_inc = r_wait_cnt + 32'd1;
  // This cycle's stall is the WAIT_LIMIT-th in a row, so the write gives up.
  assign w_timeout = (WAIT_LIMIT > 0) && (w_cnt_inc == 32'(WAIT_LIMIT));

  // Lane mapping. Shifts by 8*a use {a, 3'b000}. For swl, (3 - a) equals ~a.
  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    w_wd    = 32'd0;
    case (i_opcode)
      OP_SB: begin
        w_legal = 1'b1;
        w_be    = 4'b0001 << w_a;
        w_wd    = {24'd0, i_rt_data[7:0]} << {w_a, 3'b000};
      end
      OP_SH: begin
        if (!w_a[0]) begin
          w_legal = 1'b1;
          w_be    = w_a[1] ? 4'b1100 : 4'b0011;
          w_wd    = w_a[1] ? {i_rt_data[15:0], 16'd0} : {16'd0, i_rt_data[15:0]};
        end
      end
      OP_SW: begin
        if (w_a == 2'b00) begin
          w_legal = 1'b1;
          w_be    = 4'b1111;
          w_wd    = i_rt_data;
        end
      end
      OP_SWL: begin
        w_legal = 1'b1;
        w_be    = 4'b1111 >> (~w_a);
        w_wd    = i_rt_data >> {~w_a, 3'b000};
      end
      OP_SWR: begin
        w_legal = 1'b1;
        w_be    = 4'b1111 << w_a;
        w_wd    = i_rt_data << {w_a, 3'b000};
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_clear      = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_cnt_nxt    = r_wait_cnt;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_cnt_nxt = 32'd0;
          if (w_legal) begin
            w_accept     = 1'b1;
            w_next_state = WRITE;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      WRITE: begin
        if (!i_waitrequest) begin
          w_next_state = IDLE;
          w_done_nxt   = 1'b1;
          w_clear      = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_timeout) begin
            w_next_state = IDLE;
            w_err_nxt    = 1'b1;
            w_clear      = 1'b1;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
        w_clear      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Bus fields are loaded only on the accept edge. They are zeroed when the
  // write ends, so the bus reads zero whenever the unit is idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_address    <= 32'd0;
      r_byteenable <= 4'd0;
      r_writedata  <= 32'd0;
      r_wait_cnt   <= 32'd0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_wait_cnt <= w_cnt_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      if (w_accept) begin
        r_address    <= {i_addr[31:2], 2'b00};
        r_byteenable <= w_be;
        r_writedata  <= w_wd;
      end else if (w_clear) begin
        r_address    <= 32'd0;
        r_byteenable <= 4'd0;
        r_writedata  <= 32'd0;
      end
    end
  end

  assign o_req_ready  = (r_state == IDLE);
  assign o_write      = (r_state == WRITE);
  assign o_address    = r_address;
  assign o_byteenable = r_byteenable;
  assign o_writedata  = r_writedata;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_mips_cpu_store_unit.sv
module tb_mips_cpu_store_unit;

  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SWL = 6'b101010;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SWR = 6'b101110;
  localparam logic [5:0] OP_LW  = 6'b100011;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] rt_data;
  logic [31:0] address;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic        done;
  logic        err;

  int n_pass = 0;
  int n_total = 0;

  mips_cpu_store_unit #(.WAIT_LIMIT(4)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_opcode      (opcode),
    .i_addr        (addr),
    .i_rt_data     (rt_data),
    .o_address     (address),
    .o_write       (write),
    .o_byteenable  (byteenable),
    .o_writedata   (writedata),
    .i_waitrequest (waitrequest),
    .o_done        (done),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] rt;
    logic        legal;
    logic [3:0]  be;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    else
      n_pass++;
  endtask

  // Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt);
    req_valid = 1'b1;
    opcode    = op;
    addr      = a;
    rt_data   = rt;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".ready"}, {31'd0, req_ready}, 32'd1);
    chk({name, ".write"}, {31'd0, write}, 32'd0);
    chk({name, ".address"}, address, 32'd0);
    chk({name, ".be"}, {28'd0, byteenable}, 32'd0);
    chk({name, ".wd"}, writedata, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{OP_SB,  32'h1003, 32'h000000AB, 1'b1, 4'b1000, 32'hAB000000};
    vecs[1]  = '{OP_SB,  32'h1000, 32'h123456CD, 1'b1, 4'b0001, 32'h000000CD};
    vecs[2]  = '{OP_SB,  32'h1001, 32'h123456CD, 1'b1, 4'b0010, 32'h0000CD00};
    vecs[3]  = '{OP_SH,  32'h2000, 32'hAAAABEEF, 1'b1, 4'b0011, 32'h0000BEEF};
    vecs[4]  = '{OP_SH,  32'h2002, 32'hAAAABEEF, 1'b1, 4'b1100, 32'hBEEF0000};
    vecs[5]  = '{OP_SW,  32'h3000, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF};
    vecs[6]  = '{OP_SWL, 32'h2001, 32'h11223344, 1'b1, 4'b0011, 32'h00001122};
    vecs[7]  = '{OP_SWL, 32'h2000, 32'h11223344, 1'b1, 4'b0001, 32'h00000011};
    vecs[8]  = '{OP_SWL, 32'h2002, 32'h11223344, 1'b1, 4'b0111, 32'h00112233};
    vecs[9]  = '{OP_SWL, 32'h2003, 32'h11223344, 1'b1, 4'b1111, 32'h11223344};
    vecs[10] = '{OP_SWR, 32'h2000, 32'h11223344, 1'b1, 4'b1111, 32'h11223344};
    vecs[11] = '{OP_SWR, 32'h2001, 32'h11223344, 1'b1, 4'b1110, 32'h22334400};
    vecs[12] = '{OP_SWR, 32'h2002, 32'h11223344, 1'b1, 4'b1100, 32'h33440000};
    vecs[13] = '{OP_SWR, 32'h2003, 32'h11223344, 1'b1, 4'b1000, 32'h44000000};
    vecs[14] = '{OP_SH,  32'h4001, 32'h12345678, 1'b0, 4'b0000, 32'h0};
    vecs[15] = '{OP_SH,  32'h4003, 32'h12345678, 1'b0, 4'b0000, 32'h0};
    vecs[16] = '{OP_SW,  32'h4002, 32'h12345678, 1'b0, 4'b0000, 32'h0};
    vecs[17] = '{OP_SW,  32'h4001, 32'h12345678, 1'b0, 4'b0000, 32'h0};
    vecs[18] = '{OP_LW,  32'h4000, 32'h12345678, 1'b0, 4'b0000, 32'h0};

    reset       = 1'b1;
    req_valid   = 1'b0;
    opcode      = 6'd0;
    addr        = 32'd0;
    rt_data     = 32'd0;
    waitrequest = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_idle("reset");
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.err", {31'd0, err}, 32'd0);

    for (int i = 0; i < 19; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      waitrequest = 1'b0;
      issue(vecs[i].op, vecs[i].a, vecs[i].rt);
      if (vecs[i].legal) begin
        chk({nm, ".write"}, {31'd0, write}, 32'd1);
        chk({nm, ".ready"}, {31'd0, req_ready}, 32'd0);
        chk({nm, ".address"}, address, vecs[i].a & 32'hFFFF_FFFC);
        chk({nm, ".be"}, {28'd0, byteenable}, {28'd0, vecs[i].be});
        chk({nm, ".wd"}, writedata, vecs[i].wd);
        chk({nm, ".done_early"}, {31'd0, done}, 32'd0);
        tick();
        chk({nm, ".done"}, {31'd0, done}, 32'd1);
        chk({nm, ".err"}, {31'd0, err}, 32'd0);
        chk_idle({nm, ".after"});
      end else begin
        chk({nm, ".err"}, {31'd0, err}, 32'd1);
        chk({nm, ".done"}, {31'd0, done}, 32'd0);
        chk_idle({nm, ".rej"});
      end
      tick();
      chk({nm, ".pulse_end"}, {30'd0, done, err}, 32'd0);
      chk({nm, ".write_end"}, {31'd0, write}, 32'd0);
    end

    // Stalled sw: three stall cycles, then completion. The inputs change during
    // the write; the bus outputs must keep the values captured on the accept edge.
    waitrequest = 1'b1;
    issue(OP_SW, 32'h3000, 32'hDEADBEEF);
    addr    = 32'h5555_5557;
    rt_data = 32'h0;
    opcode  = OP_SB;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall%0d.write", i), {31'd0, write}, 32'd1);
      chk($sformatf("stall%0d.address", i), address, 32'h3000);
      chk($sformatf("stall%0d.be", i), {28'd0, byteenable}, 32'hF);
      chk($sformatf("stall%0d.wd", i), writedata, 32'hDEADBEEF);
      chk($sformatf("stall%0d.pulse", i), {30'd0, done, err}, 32'd0);
      waitrequest = (i < 3);
      tick();
    end
    chk("stall.done", {31'd0, done}, 32'd1);
    chk("stall.err", {31'd0, err}, 32'd0);
    chk_idle("stall.after");
    tick();
    chk("stall.single_done", {31'd0, done}, 32'd0);

    // A waitrequest held high hits the 4-cycle limit.
    waitrequest = 1'b1;
    issue(OP_SW, 32'h6000, 32'h01020304);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tmo%0d.write", i), {31'd0, write}, 32'd1);
      chk($sformatf("tmo%0d.pulse", i), {30'd0, done, err}, 32'd0);
      tick();
    end
    chk("tmo.err", {31'd0, err}, 32'd1);
    chk("tmo.done", {31'd0, done}, 32'd0);
    chk_idle("tmo.after");
    tick();
    chk("tmo.err_end", {31'd0, err}, 32'd0);
    chk("tmo.write_end", {31'd0, write}, 32'd0);

    // Reset arrives in the second cycle of a stalled write.
    waitrequest = 1'b1;
    issue(OP_SW, 32'h7000, 32'hCAFEF00D);
    chk("rstw.write1", {31'd0, write}, 32'd1);
    tick();
    chk("rstw.write2", {31'd0, write}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("rstw.after");
    chk("rstw.pulse", {30'd0, done, err}, 32'd0);
    waitrequest = 1'b0;
    tick();
    chk("rstw.pulse2", {30'd0, done, err}, 32'd0);

    // A new request is accepted in the cycle that done is high.
    waitrequest = 1'b0;
    issue(OP_SB, 32'h8002, 32'h000000EE);
    chk("b2b.write1", {31'd0, write}, 32'd1);
    tick();
    chk("b2b.done1", {31'd0, done}, 32'd1);
    issue(OP_SH, 32'h8002, 32'h0000ABCD);
    chk("b2b.write2", {31'd0, write}, 32'd1);
    chk("b2b.be2", {28'd0, byteenable}, 32'hC);
    chk("b2b.wd2", writedata, 32'hABCD0000);
    tick();
    chk("b2b.done2", {31'd0, done}, 32'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
